// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Purpose
//   Watches N_CH synchronous input lines for rising/falling edges, latches each
//   detected edge into a per-channel pending bit (one for rise, one for fall)
//   and offers the pending events one at a time to a consumer over a
//   valid/ready handshake. Channels are served round-robin; within a channel
//   a pending rise is served before a pending fall. An edge that arrives while
//   its pending bit is still waiting sets a sticky per-channel overflow flag.
//
// Handshake
//   evt_valid is high exactly while the FSM is in OFFER. While evt_valid=1 and
//   evt_ready=0 the offered event (evt_ch, evt_fall, evt_ts) is held stable.
//   A transfer happens on a rising clk edge where evt_valid & evt_ready = 1.
//   After a transfer the FSM always spends one cycle in IDLE, so the peak rate
//   is one event every two cycles.
//
// Optional feature (macro EDGE_ARB_TIMESTAMP_EN)
//   Defined: a free-running 16-bit cycle counter is sampled into a per-pending
//   bit timestamp at detection time and presented on evt_ts with the event.
//   An overflowing edge keeps the older (first) timestamp. Undefined: no
//   counter, no timestamp storage, no evt_ts port.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   a          in   [N_CH]  monitored lines (already synchronous to clk)
//   en_rise    in   [N_CH]  per-channel rising-edge capture enable
//   en_fall    in   [N_CH]  per-channel falling-edge capture enable
//   evt_valid  out  event offered
//   evt_ready  in   consumer accepts offered event
//   evt_ch     out  [CLR_W] channel index of offered event
//   evt_fall   out  0 = rising event, 1 = falling event
//   ovf        out  [N_CH]  sticky overflow flags
//   clr_ovf    in   [N_CH]  overflow clear pulses (set wins over clear)
//   evt_ts     out  [16]    timestamp of offered event (macro only)
//   dbg_state  out  FSM state, 0 = IDLE, 1 = OFFER
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int CLR_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  a,
  input  logic [N_CH-1:0]  en_rise,
  input  logic [N_CH-1:0]  en_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CLR_W-1:0] evt_ch,
  output logic             evt_fall,
  output logic [N_CH-1:0]  ovf,
  input  logic [N_CH-1:0]  clr_ovf,
`ifdef EDGE_ARB_TIMESTAMP_EN
  output logic [15:0]      evt_ts,
`endif
  output logic             dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [N_CH-1:0]  a_dly;
  logic [N_CH-1:0]  pend_r;
  logic [N_CH-1:0]  pend_f;
  logic [CLR_W-1:0] rr_ptr;

  // Edge detection, qualified by the per-type enables
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;

  // Handshake and the pending bit it consumes this cycle
  logic             hs;
  logic [N_CH-1:0]  cons_r;
  logic [N_CH-1:0]  cons_f;

  logic [N_CH-1:0]  pend_r_nxt;
  logic [N_CH-1:0]  pend_f_nxt;
  logic [N_CH-1:0]  ovf_set;
  logic [N_CH-1:0]  ovf_nxt;

  // Round-robin winner among currently pending channels
  logic             win_found;
  logic [CLR_W-1:0] win_ch;
  logic             win_fall;
  logic             load_evt;
  logic [CLR_W-1:0] rr_nxt;

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [15:0]      cnt;
  logic [15:0]      ts_r [N_CH];
  logic [15:0]      ts_f [N_CH];
  logic [N_CH-1:0]  ts_load_r;
  logic [N_CH-1:0]  ts_load_f;
  logic [15:0]      win_ts;
`endif

  assign evt_valid = (state == OFFER);
  assign dbg_state = (state == OFFER);

  assign rise = a & ~a_dly & en_rise;
  assign fall = ~a & a_dly & en_fall;
  assign hs   = (state == OFFER) && evt_ready;

  always_comb begin
    cons_r = '0;
    cons_f = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (hs && (evt_ch == CLR_W'(i))) begin
        cons_r[i] = !evt_fall;
        cons_f[i] = evt_fall;
      end
    end
  end

  // A new edge always leaves its bit set. It only counts as an overflow when
  // the bit was already set and is not being handed off in this same cycle.
  assign pend_r_nxt = (pend_r & ~cons_r) | rise;
  assign pend_f_nxt = (pend_f & ~cons_f) | fall;
  assign ovf_set    = (rise & pend_r & ~cons_r) | (fall & pend_f & ~cons_f);
  assign ovf_nxt    = (ovf & ~clr_ovf) | ovf_set;

`ifdef EDGE_ARB_TIMESTAMP_EN
  // Timestamp is captured only when the edge starts a fresh pending event;
  // an overflowing edge must not overwrite the older value.
  assign ts_load_r = rise & ~(pend_r & ~cons_r);
  assign ts_load_f = fall & ~(pend_f & ~cons_f);
`endif

  // Search from rr_ptr upward with wrap; first channel with anything pending
  // wins, and its rise bit takes priority over its fall bit.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    win_fall  = 1'b0;
`ifdef EDGE_ARB_TIMESTAMP_EN
    win_ts    = '0;
`endif
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!win_found && (pend_r[idx] || pend_f[idx])) begin
        win_found = 1'b1;
        win_ch    = CLR_W'(idx);
        win_fall  = !pend_r[idx];
`ifdef EDGE_ARB_TIMESTAMP_EN
        win_ts    = pend_r[idx] ? ts_r[idx] : ts_f[idx];
`endif
      end
    end
  end

  // Next round-robin start: the channel after the one just served
  assign rr_nxt = (evt_ch == CLR_W'(N_CH - 1)) ? '0 : (evt_ch + CLR_W'(1));

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    load_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = OFFER;
          load_evt  = 1'b1;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dly    <= '0;
      pend_r   <= '0;
      pend_f   <= '0;
      ovf      <= '0;
      rr_ptr   <= '0;
      evt_ch   <= '0;
      evt_fall <= 1'b0;
    end else begin
      a_dly  <= a;
      pend_r <= pend_r_nxt;
      pend_f <= pend_f_nxt;
      ovf    <= ovf_nxt;
      if (load_evt) begin
        evt_ch   <= win_ch;
        evt_fall <= win_fall;
      end
      if (hs) begin
        rr_ptr <= rr_nxt;
      end
    end
  end

`ifdef EDGE_ARB_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      evt_ts <= '0;
      for (int i = 0; i < N_CH; i++) begin
        ts_r[i] <= '0;
        ts_f[i] <= '0;
      end
    end else begin
      cnt <= cnt + 16'd1;
      if (load_evt) begin
        evt_ts <= win_ts;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (ts_load_r[i]) begin
          ts_r[i] <= cnt;
        end
        if (ts_load_f[i]) begin
          ts_f[i] <= cnt;
        end
      end
    end
  end
`endif

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4, meaning number of monitored input lines (2..16).
REQ-002 Parameter CLR_W, fixed at $clog2(N_CH), meaning width of the channel index.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 a  input  N_CH  monitored lines, already synchronous to clk.
REQ-006 en_rise  input  N_CH  per-channel rising-edge capture enable.
REQ-007 en_fall  input  N_CH  per-channel falling-edge capture enable.
REQ-008 evt_valid  output  1  event offered to consumer.
REQ-009 evt_ready  input  1  consumer accepts offered event.
REQ-010 evt_ch  output  CLR_W  channel index of offered event.
REQ-011 evt_fall  output  1  0 = rising event, 1 = falling event.
REQ-012 ovf  output  N_CH  sticky per-channel overflow flags.
REQ-013 clr_ovf  input  N_CH  per-channel overflow clear, one-cycle pulse.

Function
REQ-014 Per channel the block SHALL hold a_dly (previous sample), pend_r and pend_f bits.
REQ-015 Rise on ch i: a[i]=1 & a_dly[i]=0 & en_rise[i]; fall: a[i]=0 & a_dly[i]=1 & en_fall[i]; detected edge SHALL set the pending bit at the same clock edge.
REQ-016 Edge detected while its pending bit is already 1 and not being consumed SHALL keep the bit 1 and set ovf[i].
REQ-017 Edge detected in the cycle its pending bit is consumed SHALL leave the bit 1, no overflow.
REQ-018 Disabled edge types SHALL be ignored; clearing an enable SHALL NOT clear an existing pending bit.
REQ-019 FSM states IDLE and OFFER; IDLE->OFFER when any pending bit is set; OFFER->IDLE on evt_valid & evt_ready.
REQ-020 In IDLE, winner SHALL be first channel with any pending bit, searching round-robin from rr_ptr upward with wrap N_CH-1 -> 0; evt_ch/evt_fall registered on entering OFFER.
REQ-021 Within one channel, pend_r SHALL win over pend_f.
REQ-022 evt_valid SHALL equal (state==OFFER); evt_ch and evt_fall SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-023 On handshake the selected pending bit SHALL clear and rr_ptr SHALL become evt_ch+1 (wrap to 0); if the same channel still has pend_f it is served only after other pending channels.
REQ-024 Latency: edge at clock k -> evt_valid high from clock k+1 when FSM idle and no other pending; max throughput one event per 2 cycles.
REQ-025 clr_ovf[i] SHALL clear ovf[i]; simultaneous set and clear SHALL leave ovf[i]=1.

Reset
REQ-026 rst_n=0 at a clock edge SHALL set evt_valid, evt_ch, evt_fall, ovf, pend_r, pend_f, a_dly, rr_ptr to 0 and state to IDLE.
REQ-027 Reset mid-OFFER SHALL drop the event without handshake; a line high at reset release SHALL yield a rising event if enabled.

Configuration
REQ-028 Macro EDGE_ARB_TIMESTAMP_EN defined: free-running 16-bit cycle counter (reset 0, wraps 0xFFFF->0), per-pending-bit 16-bit stored counter value at detection, output evt_ts[15:0] (reset 0) stable with evt_ch; overflow keeps the older timestamp.
REQ-029 Macro undefined: no counter, no timestamp storage, no evt_ts port; all other behaviour identical.

Verification
REQ-030 Reset, N_CH=4, all enables 1, a=0000, evt_ready=1; a[2] 0->1 -> evt_valid=1, evt_ch=2, evt_fall=0 one cycle after edge, then evt_valid=0.
REQ-031 a rises on ch0,1,3 same cycle, evt_ready=1 -> events served ch0, ch1, ch3 in that order, 2 cycles apart.
REQ-032 evt_ready=0, a[1] toggles 0->1->0->1 -> ovf[1]=1 after second rise; release ready -> one rise, one fall on ch1; clr_ovf[1] pulse -> ovf[1]=0.
REQ-033 en_fall[0]=0, a[0] pulses high 3 cycles -> only rise event ch0, no fall event.
REQ-034 Assert rst_n=0 while evt_valid=1, evt_ready=0 -> next cycle evt_valid=0, ovf=0, no stale event after release.
REQ-035 With EDGE_ARB_TIMESTAMP_EN, rise on ch3 at counter 0xFFFE, ready held 0 for 5 cycles -> evt_ts=0xFFFE at handshake.
